// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: response/burst codes, FSM encodings and response decode shared by the AXI memory slave
package axi_mem_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [1:0] addr_resp(input logic dec, input logic [2:0] size, input logic [1:0] burst);
    return dec ? RESP_DECERR : (size != SIZE_4B || burst != BURST_INCR) ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi_mem_array.sv
// axi_mem_array: word array with one byte-strobed synchronous write port and one asynchronous read port
module axi_mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 INCR-burst slave over on-chip word memory, independent read and write engines
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        S_ARID,
  input  logic [31:0] S_ARADDR,
  input  logic [7:0]  S_ARLEN,
  input  logic [2:0]  S_ARSIZE,
  input  logic [1:0]  S_ARBURST,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  output logic        S_RID,
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RLAST,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  input  logic        S_AWID,
  input  logic [31:0] S_AWADDR,
  input  logic [7:0]  S_AWLEN,
  input  logic [2:0]  S_AWSIZE,
  input  logic [1:0]  S_AWBURST,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  input  logic [31:0] S_WDATA,
  input  logic [7:0]  S_WSTRB,
  input  logic        S_WLAST,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  output logic        S_BID,
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY
);
  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] aw_off, ar_off, mem_rdata;
  logic aw_dec, ar_dec, aw_hs, w_hs, b_hs, ar_hs, r_hs, we, unused;
  logic [ADDR_WIDTH-1:0] w_idx, r_idx, raddr;
  logic [7:0] w_rem, r_rem;
  // an address below the base wraps to a huge offset, so one compare covers both bounds
  assign aw_off = S_AWADDR - BASE_ADDR;
  assign ar_off = S_ARADDR - BASE_ADDR;
  assign aw_dec = {1'b0, aw_off} >= SPAN;
  assign ar_dec = {1'b0, ar_off} >= SPAN;
  assign unused = ^{S_WSTRB[7:4], aw_off, ar_off};
  assign we = w_hs && S_BRESP != RESP_DECERR;
  always_comb begin
    S_AWREADY = !ARESET && w_state == W_IDLE;
    S_WREADY = !ARESET && w_state == W_DATA;
    S_BVALID = w_state == W_RESP;
    aw_hs = S_AWVALID && S_AWREADY;
    w_hs = S_WVALID && S_WREADY;
    b_hs = S_BVALID && S_BREADY;
    w_next = aw_hs ? W_DATA : (w_hs && w_rem == '0) ? W_RESP : b_hs ? W_IDLE : w_state;
  end
  always_ff @(posedge ACLK) w_state <= ARESET ? W_IDLE : w_next;
  always_ff @(posedge ACLK)
    if (ARESET) begin
      w_idx <= '0;
      w_rem <= '0;
      S_BID <= 1'b0;
      S_BRESP <= RESP_OKAY;
    end else if (aw_hs) begin
      w_idx <= aw_off[ADDR_WIDTH+1:2];
      w_rem <= S_AWLEN;
      S_BID <= S_AWID;
      S_BRESP <= addr_resp(aw_dec, S_AWSIZE, S_AWBURST);
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_rem <= w_rem - 1'b1;
      if (S_WLAST != (w_rem == '0) && S_BRESP != RESP_DECERR) S_BRESP <= RESP_SLVERR;
    end
  always_comb begin
    S_ARREADY = !ARESET && r_state == R_IDLE;
    S_RVALID = r_state == R_DATA;
    ar_hs = S_ARVALID && S_ARREADY;
    r_hs = S_RVALID && S_RREADY;
    r_next = ar_hs ? R_DATA : (r_hs && S_RLAST) ? R_IDLE : r_state;
    raddr = r_state == R_IDLE ? ar_off[ADDR_WIDTH+1:2] : r_idx;
  end
  always_ff @(posedge ACLK) r_state <= ARESET ? R_IDLE : r_next;
  // r_idx always points one word ahead of the beat on RDATA so the next beat loads on the handshake edge
  always_ff @(posedge ACLK)
    if (ARESET) begin
      r_idx <= '0;
      r_rem <= '0;
      S_RID <= 1'b0;
      S_RRESP <= RESP_OKAY;
      S_RDATA <= '0;
      S_RLAST <= 1'b0;
    end else if (ar_hs) begin
      r_idx <= ar_off[ADDR_WIDTH+1:2] + 1'b1;
      r_rem <= S_ARLEN;
      S_RID <= S_ARID;
      S_RRESP <= addr_resp(ar_dec, S_ARSIZE, S_ARBURST);
      S_RDATA <= ar_dec ? '0 : mem_rdata;
      S_RLAST <= S_ARLEN == '0;
    end else if (r_hs) begin
      r_idx <= r_idx + 1'b1;
      r_rem <= r_rem - 1'b1;
      S_RDATA <= S_RRESP == RESP_DECERR ? '0 : mem_rdata;
      S_RLAST <= r_rem == 8'd1;
    end
  axi_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk(ACLK),
    .we(we),
    .waddr(w_idx),
    .wstrb(S_WSTRB[3:0]),
    .wdata(S_WDATA),
    .raddr(raddr),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: vector table, hand sequences and random bursts against a word-array model of the memory
module tb_axi_mem_slave;
  localparam int AW = 10;
  localparam int MEM = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic ACLK = 0, ARESET = 1;
  logic S_ARID = 0, S_ARVALID = 0, S_RREADY = 0, S_AWID = 0, S_AWVALID = 0, S_WLAST = 0, S_WVALID = 0, S_BREADY = 0;
  logic [31:0] S_ARADDR = 0, S_AWADDR = 0, S_WDATA = 0;
  logic [7:0] S_ARLEN = 0, S_AWLEN = 0, S_WSTRB = 0;
  logic [2:0] S_ARSIZE = 3'b010, S_AWSIZE = 3'b010;
  logic [1:0] S_ARBURST = 2'b01, S_AWBURST = 2'b01;
  logic S_ARREADY, S_RID, S_RLAST, S_RVALID, S_AWREADY, S_WREADY, S_BID, S_BVALID;
  logic [31:0] S_RDATA;
  logic [1:0] S_RRESP, S_BRESP;
  int tests = 0, fails = 0;
  logic [31:0] ref_mem [MEM];
  logic [31:0] wd [256];
  logic [3:0] ws [256];
  logic [31:0] first_data;
  typedef struct {
    logic [31:0] addr; int len; logic [2:0] size; logic [1:0] burst;
    logic [31:0] d0; logic [31:0] step; logic [3:0] strb; int bad; int rmode;
    logic [1:0] bresp; logic [1:0] rresp; logic [31:0] first;
  } vec_t;
  vec_t tbl [12];

  axi_mem_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY)
  );

  always #5 ACLK = ~ACLK;
  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * MEM;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % MEM);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu, input bit bad);
    return !in_range(a) ? 2'b11 : (sz != 3'b010 || bu != 2'b01 || bad) ? 2'b10 : 2'b00;
  endfunction

  task automatic wr(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                    input int bad, input int bwait, input logic id, input logic [1:0] exp);
    int n, lat, i;
    S_AWADDR = addr; S_AWLEN = 8'(len); S_AWSIZE = size; S_AWBURST = burst; S_AWID = id; S_AWVALID = 1;
    n = 0;
    while (!S_AWREADY && n < 100) begin step(); n++; end
    if (!S_AWREADY) begin tmo("aw_ready"); S_AWVALID = 0; return; end
    step();
    S_AWVALID = 0;
    lat = 1;
    for (int b = 0; b <= len; b++) begin
      S_WVALID = 1; S_WDATA = wd[b]; S_WSTRB = {4'($urandom), ws[b]}; S_WLAST = (b == len) ^ (b == bad);
      n = 0;
      while (!S_WREADY && n < 100) begin step(); n++; lat++; end
      if (!S_WREADY) begin tmo("w_ready"); S_WVALID = 0; return; end
      step();
      lat++;
      if (in_range(addr)) begin
        i = (widx(addr) + b) % MEM;
        for (int k = 0; k < 4; k++) if (ws[b][k]) ref_mem[i][8*k +: 8] = wd[b][8*k +: 8];
      end
    end
    S_WVALID = 0; S_WLAST = 0;
    n = 0;
    while (!S_BVALID && n < 100) begin step(); n++; lat++; end
    if (!S_BVALID) begin tmo("b_valid"); return; end
    check("aw_to_b_latency", lat, len + 2);
    check("bresp", S_BRESP, exp);
    check("bid", S_BID, id);
    for (int c = 0; c < bwait; c++) begin
      step();
      check("b_hold", {S_BVALID, S_AWREADY, S_BRESP, S_BID}, {2'b10, exp, id});
    end
    S_BREADY = 1;
    step();
    S_BREADY = 0;
    check("b_done", {S_BVALID, S_AWREADY}, 2'b01);
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                    input logic id, input int mode, input logic [1:0] exp);
    int n, got, c;
    bit rr;
    logic [31:0] pd, ed;
    logic pl, pi;
    logic [1:0] pr;
    S_ARADDR = addr; S_ARLEN = 8'(len); S_ARSIZE = size; S_ARBURST = burst; S_ARID = id; S_ARVALID = 1;
    n = 0;
    while (!S_ARREADY && n < 100) begin step(); n++; end
    if (!S_ARREADY) begin tmo("ar_ready"); S_ARVALID = 0; return; end
    step();
    S_ARVALID = 0;
    check("r_first_latency", S_RVALID, 1);
    got = 0;
    c = 0;
    while (got <= len && c < 8 * (len + 1) + 20) begin
      rr = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      S_RREADY = rr;
      check("r_no_bubble", S_RVALID, 1);
      pd = S_RDATA; pl = S_RLAST; pr = S_RRESP; pi = S_RID;
      ed = in_range(addr) ? ref_mem[(widx(addr) + got) % MEM] : 32'h0;
      step();
      c++;
      if (rr) begin
        check("r_data", pd, ed);
        check("r_last", pl, got == len);
        check("r_resp", pr, exp);
        check("r_id", pi, id);
        if (got == 0) first_data = pd;
        got++;
      end else begin
        check("r_stall_stable", {S_RDATA, S_RLAST, S_RRESP, S_RID}, {pd, pl, pr, pi});
      end
    end
    S_RREADY = 0;
    if (got <= len) begin tmo("r_beats"); return; end
    check("r_end", {S_RVALID, S_ARREADY}, 2'b01);
  endtask

  initial begin
    logic [31:0] addr, old;
    logic [2:0] sz;
    logic [1:0] bu;
    int len, bad;
    logic id;
    for (int i = 0; i < MEM; i++) ref_mem[i] = 0;
    tbl[0]  = '{32'h10,        3, 3'b010, 2'b01, 32'h11,        32'h11,  4'hF, -1, 0, 2'b00, 2'b00, 32'h11};
    tbl[1]  = '{32'h0,         0, 3'b010, 2'b01, 32'h0,         32'h0,   4'hF, -1, 0, 2'b00, 2'b00, 32'h0};
    tbl[2]  = '{32'h0,         0, 3'b010, 2'b01, 32'hAABBCCDD,  32'h0,   4'h5, -1, 0, 2'b00, 2'b00, 32'h00BB00DD};
    tbl[3]  = '{32'h40,        0, 3'b010, 2'b01, 32'h12345678,  32'h0,   4'hF,  0, 0, 2'b10, 2'b00, 32'h12345678};
    tbl[4]  = '{32'h80,        3, 3'b010, 2'b01, 32'hA0,        32'h1,   4'hF,  1, 0, 2'b10, 2'b00, 32'hA0};
    tbl[5]  = '{32'h1000,      1, 3'b010, 2'b01, 32'hDEAD0000,  32'h1,   4'hF, -1, 0, 2'b11, 2'b11, 32'h0};
    tbl[6]  = '{32'h100,       7, 3'b010, 2'b01, 32'h70,        32'h101, 4'hF, -1, 1, 2'b00, 2'b00, 32'h70};
    tbl[7]  = '{32'h200,       2, 3'b011, 2'b01, 32'h5150,      32'h1,   4'hF, -1, 0, 2'b10, 2'b10, 32'h5150};
    tbl[8]  = '{32'h300,       2, 3'b010, 2'b10, 32'h8080,      32'h1,   4'hF, -1, 0, 2'b10, 2'b10, 32'h8080};
    tbl[9]  = '{32'hFF8,       3, 3'b010, 2'b01, 32'hC0DE0000,  32'h1,   4'hF, -1, 0, 2'b00, 2'b00, 32'hC0DE0000};
    tbl[10] = '{32'h23,        0, 3'b010, 2'b01, 32'h2323,      32'h0,   4'hF, -1, 0, 2'b00, 2'b00, 32'h2323};
    tbl[11] = '{32'hFFFF_FFF0, 0, 3'b010, 2'b01, 32'h5A5A5A5A,  32'h0,   4'hF, -1, 0, 2'b11, 2'b11, 32'h0};
    repeat (3) step();
    check("reset_outputs", {S_AWREADY, S_WREADY, S_BVALID, S_BID, S_BRESP, S_ARREADY, S_RVALID, S_RID, S_RDATA, S_RRESP, S_RLAST}, 44'h0);
    ARESET = 0;
    #1;
    check("ready_after_reset", {S_AWREADY, S_ARREADY}, 2'b11);
    // fill the whole memory so every read has a known expected value
    for (int q = 0; q < 4; q++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      wr(BASE + 32'(q * 1024), 255, 3'b010, 2'b01, -1, 0, 1'b0, 2'b00);
    end
    foreach (tbl[t]) begin
      for (int b = 0; b <= tbl[t].len; b++) begin wd[b] = tbl[t].d0 + 32'(b) * tbl[t].step; ws[b] = tbl[t].strb; end
      wr(tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, tbl[t].bad, t % 3, 1'(t), tbl[t].bresp);
      rd(tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, 1'(t + 1), tbl[t].rmode, tbl[t].rresp);
      check("vec_first_word", first_data, tbl[t].first);
    end
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    wr(BASE + 32'h1000, 0, 3'b010, 2'b01, -1, 0, 1'b0, 2'b11);
    rd(BASE, 1, 3'b010, 2'b01, 1'b0, 0, 2'b00);
    // write beat and read load of the same word on one edge: read sees the old value
    old = ref_mem[100];
    S_AWADDR = 32'h190; S_AWLEN = 0; S_AWSIZE = 3'b010; S_AWBURST = 2'b01; S_AWID = 1; S_AWVALID = 1;
    step();
    S_AWVALID = 0;
    S_WDATA = 32'h600D_F00D; S_WSTRB = 8'h0F; S_WLAST = 1; S_WVALID = 1;
    S_ARADDR = 32'h190; S_ARLEN = 0; S_ARSIZE = 3'b010; S_ARBURST = 2'b01; S_ARID = 0; S_ARVALID = 1;
    step();
    S_WVALID = 0; S_WLAST = 0; S_ARVALID = 0;
    check("collide_old_data", {S_RVALID, S_RDATA}, {1'b1, old});
    ref_mem[100] = 32'h600D_F00D;
    S_RREADY = 1;
    step();
    S_RREADY = 0;
    check("collide_bvalid", {S_BVALID, S_BRESP, S_RVALID}, {1'b1, 2'b00, 1'b0});
    S_BREADY = 1;
    step();
    S_BREADY = 0;
    rd(32'h190, 0, 3'b010, 2'b01, 1'b1, 0, 2'b00);
    for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    fork
      wr(BASE + 32'h800, 7, 3'b010, 2'b01, -1, 5, 1'b1, 2'b00);
      rd(BASE + 32'h0, 15, 3'b010, 2'b01, 1'b0, 0, 2'b00);
    join
    S_ARADDR = 32'h400; S_ARLEN = 7; S_ARSIZE = 3'b010; S_ARBURST = 2'b01; S_ARID = 0; S_ARVALID = 1;
    step();
    S_ARVALID = 0;
    S_RREADY = 1;
    repeat (2) step();
    check("pre_reset_beat2", S_RDATA, ref_mem[258]);
    S_RREADY = 0;
    ARESET = 1;
    step();
    ARESET = 0;
    #1;
    check("mid_burst_reset", {S_RVALID, S_ARREADY, S_RLAST, S_RDATA}, {3'b010, 32'h0});
    rd(32'h400, 7, 3'b010, 2'b01, 1'b1, 0, 2'b00);
    for (int it = 0; it < 30; it++) begin
      addr = $urandom_range(0, 7) == 0 ? 32'h1000 + 32'($urandom_range(0, 1000)) * 4 : 32'($urandom_range(0, 4095));
      len = $urandom_range(0, 3) == 0 ? $urandom_range(16, 63) : $urandom_range(0, 15);
      sz = $urandom_range(0, 9) == 0 ? 3'b000 : 3'b010;
      bu = $urandom_range(0, 9) == 0 ? 2'b00 : 2'b01;
      bad = $urandom_range(0, 5) == 0 ? $urandom_range(0, len) : -1;
      id = 1'($urandom);
      for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
      wr(addr, len, sz, bu, bad, $urandom_range(0, 3), id, exp_resp(addr, sz, bu, bad >= 0));
      rd(addr, len, sz, bu, ~id, 2, exp_resp(addr, sz, bu, 1'b0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 full slave responder backed by on-chip word memory: the other end of the data-mover master's AR/R/AW/W/B channels.
- Used as the memory model in block- and top-level benches, and as a scratch BRAM target on the fabric.
- Independent read and write engines, one outstanding burst each, 32-bit data, INCR bursts of 1..256 beats.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words (default 4 KiB)
BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to 4*2**ADDR_WIDTH

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous active-high reset
S_ARID  in  1  read ID
S_ARADDR  in  32  read start byte address
S_ARLEN  in  8  beats-1
S_ARSIZE  in  3  must be 3'b010
S_ARBURST  in  2  must be 2'b01 (INCR)
S_ARVALID  in  1  / S_ARREADY out 1  AR handshake
S_RID  out  1  echoed ARID
S_RDATA  out  32  read data
S_RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
S_RLAST  out  1  last beat
S_RVALID  out  1  / S_RREADY in 1  R handshake
S_AWID  in  1  / S_AWADDR in 32 / S_AWLEN in 8 / S_AWSIZE in 3 / S_AWBURST in 2  write address
S_AWVALID  in  1  / S_AWREADY out 1  AW handshake
S_WDATA  in  32  write data
S_WSTRB  in  8  byte strobes; bits [3:0] used, [7:4] ignored
S_WLAST  in  1  master's last flag
S_WVALID  in  1  / S_WREADY out 1  W handshake
S_BID  out  1  echoed AWID
S_BRESP  out  2  write response
S_BVALID  out  1  / S_BREADY in 1  B handshake

Behaviour:
- Reset: every output 0, both FSMs to IDLE, latched addr/len/id/error cleared; memory contents NOT cleared. Reset mid-burst abandons it, no response issued.
- Word index = (ADDR - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits; increments by 1 per beat and wraps modulo memory size. ADDR[1:0] ignored.
- Decode error: start address outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH) makes the whole burst DECERR: writes dropped, reads return 0.
- Protocol error: SIZE != 010 or BURST != 01 gives SLVERR; the access still proceeds as 32-bit INCR.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1; on handshake latch addr, len, id, error and go to W_DATA.
  - W_DATA: WREADY=1. Each handshake writes the bytes enabled by WSTRB[3:0] and increments index and beat count.
  - Exactly len+1 beats are accepted. The beat where count==len moves to W_RESP.
  - WLAST asserted early, or absent on beat len, sets SLVERR (unless already DECERR); beat counting is unaffected.
  - W_RESP: BVALID=1, held with BID/BRESP stable until BREADY, then W_IDLE.
  - AW to BVALID latency: len+2 cycles minimum with WVALID continuously high.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1; on handshake RDATA <= mem[start], RVALID=1 the next cycle (latency 1).
  - R_DATA: RDATA/RRESP/RLAST/RID held stable while RVALID && !RREADY.
  - On handshake of a non-last beat, the next word loads in the same edge: back-to-back beats, no bubble.
  - RLAST=1 exactly on beat len. Its handshake returns the FSM to R_IDLE with RVALID=0 and ARREADY=1 next cycle.
  - RRESP is constant for the whole burst.
- Read and write engines are fully concurrent; AW and AR accepted in the same cycle are independent.
- Same-word read-load and write in one cycle: RDATA gets the pre-write value.
- AWREADY is low outside W_IDLE and ARREADY is low outside R_IDLE, so no second outstanding burst is accepted.
- IDs are echoed unchanged; no reordering.

Decomposition:
- Package axi_mem_pkg: RESP_OKAY/SLVERR/DECERR, BURST_INCR, SIZE_4B, write/read state encodings.
- Sub-module axi_mem_array: 2**ADDR_WIDTH x 32 register array with one byte-strobed synchronous write port and one asynchronous read port. The top holds both FSMs, address decode and counters.

Test Plan:
- AW addr 0x10 len 3, 4 beats 0x11..0x44 with WSTRB 0xF, WLAST on beat 4 -> BRESP 00. Then AR 0x10 len 3 with RREADY=1 -> 0x11,0x22,0x33,0x44 on consecutive cycles, RLAST on beat 4 only, first RVALID one cycle after AR.
- Read burst len 7 with RREADY toggling 1,0,0,1 -> RDATA/RLAST stable during stalls, 8 beats, no data skipped or duplicated.
- Write 0xAABBCCDD with WSTRB 0x5 over 0x00000000 -> readback 0x00BB00DD. Write len 0 with WLAST=0 -> BRESP 10, data still written.
- AR at BASE_ADDR+4*2**ADDR_WIDTH len 1 -> 2 beats RDATA 0, RRESP 11. AW to same address -> BRESP 11, memory unchanged.
- Simultaneous AW and AR to different regions with BREADY held low 5 cycles -> read burst completes, BVALID held, AWREADY stays low until B handshake.
- ARESET pulsed mid read burst (beat 2 of 8) -> next cycle RVALID=0, ARREADY=1; a new burst returns correct data.
